// File: rtl/mux4x1_sel.sv
// Word selector for the rv32i write-back path: combinational salMux plus registered copy and illegal-select flag.
// Define MUX4X1_E4_EN to add the fourth input e4 on sel=3, which also makes every select code legal.
module mux4x1_sel #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] e1,
   input  logic [WIDTH-1:0] e2,
   input  logic [WIDTH-1:0] e3,
`ifdef MUX4X1_E4_EN
   input  logic [WIDTH-1:0] e4,
`endif
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] salMux,
   output logic [WIDTH-1:0] salMux_q,
   output logic             sel_err
);

   logic selIllegal;

   // Zero-latency decode; unmapped codes fall to the zero default so no latch can form.
   always_comb begin
      salMux     = '0;
      selIllegal = 1'b0;
      case (sel)
         2'd0: salMux = e1;
         2'd1: salMux = e2;
         2'd2: salMux = e3;
`ifdef MUX4X1_E4_EN
         2'd3: salMux = e4;
`else
         2'd3: selIllegal = 1'b1;
`endif
         default: salMux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         salMux_q <= '0;
      end else begin
         salMux_q <= salMux;
      end
   end

`ifdef MUX4X1_E4_EN
   assign sel_err = 1'b0;
   logic unusedIllegal;
   assign unusedIllegal = selIllegal;
`else
   logic selErrQ;

   // Not sticky: reflects only the select code seen at the previous edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         selErrQ <= 1'b0;
      end else begin
         selErrQ <= selIllegal;
      end
   end

   assign sel_err = selErrQ;
`endif

endmodule

// File: tb/tb_mux4x1_sel.sv
// Directed self-checking bench for mux4x1_sel; expected values are hand-computed constants.
// Covers the default build, plus the e4 path when MUX4X1_E4_EN is defined.
module tb_mux4x1_sel;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] e1;
   logic [WIDTH-1:0] e2;
   logic [WIDTH-1:0] e3;
`ifdef MUX4X1_E4_EN
   logic [WIDTH-1:0] e4;
`endif
   logic [1:0]       sel;
   logic [WIDTH-1:0] salMux;
   logic [WIDTH-1:0] salMux_q;
   logic             sel_err;

   int compared;
   int mismatched;

   mux4x1_sel #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .e1       (e1),
      .e2       (e2),
      .e3       (e3),
`ifdef MUX4X1_E4_EN
      .e4       (e4),
`endif
      .sel      (sel),
      .salMux   (salMux),
      .salMux_q (salMux_q),
      .sel_err  (sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      sel = 2'd0;
      e1  = 32'hA5A5_0001;
      #1;
      compared++;
      if (salMux !== 32'hA5A5_0001) begin
         mismatched++;
         $display("[TB] FAIL reset_comb: got %h expected %h", salMux, 32'hA5A5_0001);
      end
      tick();
      compared++;
      if (salMux_q !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_q: got %h expected %h", salMux_q, 32'h0);
      end
      compared++;
      if (sel_err !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_err: got %b expected %b", sel_err, 1'b0);
      end
   endtask

   task automatic test_step();
      logic [WIDTH-1:0] expWord;
      logic             expErr;
      @(negedge clk);
      rst = 1'b0;
      e1  = 32'd1;
      e2  = 32'd2;
      e3  = 32'd3;
`ifdef MUX4X1_E4_EN
      e4  = 32'd4;
`endif
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         sel = 2'(i);
`ifdef MUX4X1_E4_EN
         expWord = 32'(i + 1);
         expErr  = 1'b0;
`else
         expWord = (i == 3) ? 32'd0 : 32'(i + 1);
         expErr  = (i == 3);
`endif
         #1;
         compared++;
         if (salMux !== expWord) begin
            mismatched++;
            $display("[TB] FAIL step_comb sel=%0d: got %h expected %h", i, salMux, expWord);
         end
         tick();
         compared++;
         if (salMux_q !== expWord) begin
            mismatched++;
            $display("[TB] FAIL step_q sel=%0d: got %h expected %h", i, salMux_q, expWord);
         end
         compared++;
         if (sel_err !== expErr) begin
            mismatched++;
            $display("[TB] FAIL step_err sel=%0d: got %b expected %b", i, sel_err, expErr);
         end
      end
   endtask

   task automatic test_reset_hold();
      @(negedge clk);
      rst = 1'b1;
      sel = 2'd1;
      e2  = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         #1;
         compared++;
         if (salMux !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("[TB] FAIL hold_comb cyc=%0d: got %h expected %h", i, salMux, 32'hDEAD_BEEF);
         end
         tick();
         compared++;
         if (salMux_q !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL hold_q cyc=%0d: got %h expected %h", i, salMux_q, 32'h0);
         end
         compared++;
         if (sel_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hold_err cyc=%0d: got %b expected %b", i, sel_err, 1'b0);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      tick();
      compared++;
      if (salMux_q !== 32'hDEAD_BEEF) begin
         mismatched++;
         $display("[TB] FAIL hold_release_q: got %h expected %h", salMux_q, 32'hDEAD_BEEF);
      end
   endtask

   task automatic test_midcycle();
      @(negedge clk);
      sel = 2'd2;
      e3  = 32'h0000_0000;
      tick();
      compared++;
      if (salMux_q !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL mid_pre_q: got %h expected %h", salMux_q, 32'h0);
      end
      #2;
      e3 = 32'hFFFF_FFFF;
      #1;
      compared++;
      if (salMux !== 32'hFFFF_FFFF) begin
         mismatched++;
         $display("[TB] FAIL mid_comb: got %h expected %h", salMux, 32'hFFFF_FFFF);
      end
      compared++;
      if (salMux_q !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL mid_q_hold: got %h expected %h", salMux_q, 32'h0);
      end
      tick();
      compared++;
      if (salMux_q !== 32'hFFFF_FFFF) begin
         mismatched++;
         $display("[TB] FAIL mid_q: got %h expected %h", salMux_q, 32'hFFFF_FFFF);
      end
   endtask

`ifndef MUX4X1_E4_EN
   task automatic test_sel3_hold();
      @(negedge clk);
      sel = 2'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         compared++;
         if (sel_err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sel3_err cyc=%0d: got %b expected %b", i, sel_err, 1'b1);
         end
         compared++;
         if (salMux_q !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL sel3_q cyc=%0d: got %h expected %h", i, salMux_q, 32'h0);
         end
      end
      @(negedge clk);
      sel = 2'd0;
      e1  = 32'h1234_5678;
      tick();
      compared++;
      if (sel_err !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL sel3_clear_err: got %b expected %b", sel_err, 1'b0);
      end
      compared++;
      if (salMux_q !== 32'h1234_5678) begin
         mismatched++;
         $display("[TB] FAIL sel3_clear_q: got %h expected %h", salMux_q, 32'h1234_5678);
      end
   endtask

   task automatic test_reset_during_err();
      @(negedge clk);
      sel = 2'd3;
      tick();
      compared++;
      if (sel_err !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL rsterr_pre: got %b expected %b", sel_err, 1'b1);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      compared++;
      if (sel_err !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rsterr_reset: got %b expected %b", sel_err, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      compared++;
      if (sel_err !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL rsterr_release: got %b expected %b", sel_err, 1'b1);
      end
   endtask
`else
   task automatic test_e4();
      @(negedge clk);
      e4  = 32'd4;
      sel = 2'd3;
      #1;
      compared++;
      if (salMux !== 32'd4) begin
         mismatched++;
         $display("[TB] FAIL e4_comb: got %h expected %h", salMux, 32'd4);
      end
      tick();
      compared++;
      if (salMux_q !== 32'd4) begin
         mismatched++;
         $display("[TB] FAIL e4_q: got %h expected %h", salMux_q, 32'd4);
      end
      compared++;
      if (sel_err !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL e4_err: got %b expected %b", sel_err, 1'b0);
      end
   endtask
`endif

   initial begin
      compared   = 0;
      mismatched = 0;
      rst = 1'b1;
      sel = 2'd0;
      e1  = '0;
      e2  = '0;
      e3  = '0;
`ifdef MUX4X1_E4_EN
      e4  = '0;
`endif
      test_reset();
      test_step();
      test_reset_hold();
      test_midcycle();
`ifndef MUX4X1_E4_EN
      test_sel3_hold();
      test_reset_during_err();
`else
      test_e4();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
